crc_stream_engine: RTL and testbench
====================================

# crc_stream_engine

Parametrised streaming CRC engine: the next generation of the team's serial CRC calculator. It accepts a message of any number of DWIDTH-bit words over a valid/ready handshake and processes BITS_PER_CYCLE bits per clock. Initial value, polynomial, input/output reflection and final XOR are set per message, so one instance covers CRC-8/16/32 variants. It sits between a data source (packet framer, DMA) and whatever consumes the checksum.

## Interface
- CRC_WIDTH, 8: CRC register width (≥2).
- DWIDTH, 16: data word width per beat.
- BITS_PER_CYCLE, 1: bits folded per clock; must divide DWIDTH (elaboration error otherwise).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- startIn  in  1  pulse: sample config, begin new message (aborts any in progress).
- GenPoly  in  CRC_WIDTH  polynomial, implicit top bit; sampled on startIn.
- initVal  in  CRC_WIDTH  initial register value; sampled on startIn.
- xorOut  in  CRC_WIDTH  final XOR; sampled on startIn.
- reflectIn  in  1  process each word LSB-first; sampled on startIn.
- reflectOut  in  1  bit-reverse result before xorOut; sampled on startIn.
- dataValid  in  1  word available.
- dataIn  in  DWIDTH  message word.
- dataLast  in  1  final word of message, qualified by dataValid.
- dataReady  out  1  engine accepts a word this cycle.
- crcValid  out  1  crcOut holds a final result.
- crcOut  out  CRC_WIDTH  final CRC.
- crcAck  in  1  consumer takes result; clears crcValid.
- busy  out  1  state ≠ IDLE.

## Operation
- Direct (non-augmented) algorithm: per bit b, fb = crc[MSB]^b; crc = {crc[MSB-1:0],0} ^ (fb ? GenPolyReg : 0). No zero-padding of the message.
- States: IDLE → (startIn) ACCEPT → (dataValid&&dataReady) SHIFT → after N=DWIDTH/BITS_PER_CYCLE cycles: ACCEPT if word not last, DONE if last. DONE → (crcAck) IDLE.
- startIn in any state: load config, crc ← initVal, clear crcValid, go to ACCEPT. startIn beats crcAck and dataValid in the same cycle.
- dataReady = (state==ACCEPT) && !startIn. Word, dataLast captured into shift register on handshake; reflectIn bit-reverses the word at capture.
- SHIFT consumes BITS_PER_CYCLE MSBs of shift register per cycle, MSB first; beat counter width clog2(N) (min 1), wraps to 0 at N-1.
- Result: crcOut = (reflectOut ? reverse(crcNext) : crcNext) ^ xorOutReg, registered on the last SHIFT edge of the last word; held until next startIn.
- Zero-length messages are not supported (dataLast needs a beat).
- Reset values: dataReady 0, crcValid 0, crcOut 0, busy 0, state IDLE, counter 0. rst mid-message discards everything; no output glitches beyond returning to reset values.
- dataValid outside ACCEPT is ignored; source must hold word until handshake.

## Timing
- startIn at cycle 0 → dataReady high in cycle 1.
- Handshake in cycle t → SHIFT cycles t+1..t+N; dataReady (not last) or crcValid (last) high in cycle t+N+1.
- Throughput: one word per N+1 cycles; BITS_PER_CYCLE=DWIDTH gives 2 cycles/word.
- crcAck in cycle k → crcValid low, busy low in cycle k+1.
- No combinational path from inputs to outputs except dataReady from startIn.

## Structure
- Package crc_pkg: clog2 function, bit-reverse function, state enum (IDLE, ACCEPT, SHIFT, DONE), constants for standard polynomials (0x07, 0x1021, 0x04C11DB7).
- Sub-module crc_step: combinational, parameters CRC_WIDTH/BITS_PER_CYCLE; inputs crc, poly, bit slice; output next crc. Top block owns FSM, counter, registers, handshake.

## Test plan
- CRC-8 (DWIDTH=8, BPC=1, poly 0x07, init 0, no reflect, xor 0), bytes "123456789" → crcOut 0xF4, 9 cycles per byte.
- CRC-16/CCITT-FALSE (DWIDTH=8, BPC=4, poly 0x1021, init 0xFFFF) "123456789" → 0x29B1, 3 cycles per byte.
- CRC-32 (DWIDTH=8, BPC=8, poly 0x04C11DB7, init/xor 0xFFFFFFFF, both reflect) "123456789" → 0xCBF43926; random dataValid gaps give same result.
- Abort: startIn after 4 bytes, then full "123456789" CRC-8 → 0xF4; crcValid never rose for the aborted message.
- rst asserted mid-SHIFT → all outputs 0 next cycle; subsequent message correct.
- crcValid held across 20 idle cycles without crcAck; crcAck and startIn same cycle → new message starts, crcValid low.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared types and helpers for the streaming CRC engine: FSM states,
// standard polynomials, and elaboration-time / bit-order utility functions.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [7:0]  POLY_CRC8        = 8'h07;
  localparam logic [15:0] POLY_CRC16_CCITT = 16'h1021;
  localparam logic [31:0] POLY_CRC32       = 32'h04C11DB7;

  localparam int MAX_REV_W = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Reverses the low 'width' bits of v; bits above 'width' come back zero.
  function automatic logic [MAX_REV_W-1:0] bit_reverse(input logic [MAX_REV_W-1:0] v,
                                                       input int width);
    logic [MAX_REV_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_REV_W; i++) begin
      if (i < width) r[i] = v[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational fold of BITS_PER_CYCLE message bits into the CRC register,
// direct (non-augmented) algorithm, bits[BITS_PER_CYCLE-1] consumed first.
module crc_step #(
  parameter int CRC_WIDTH      = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [CRC_WIDTH-1:0]      crc,
  input  logic [CRC_WIDTH-1:0]      poly,
  input  logic [BITS_PER_CYCLE-1:0] bits,
  output logic [CRC_WIDTH-1:0]      crc_next
);

  logic [CRC_WIDTH-1:0] acc;
  logic                 fb;

  always_comb begin
    acc = crc;
    fb  = 1'b0;
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
      fb  = acc[CRC_WIDTH-1] ^ bits[i];
      acc = {acc[CRC_WIDTH-2:0], 1'b0} ^ ({CRC_WIDTH{fb}} & poly);
    end
    crc_next = acc;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: one DWIDTH word per N+1 cycles (N = DWIDTH/BITS_PER_CYCLE),
// result registered on the final shift; dataReady only in ACCEPT, result held until crcAck/startIn.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int CRC_WIDTH      = 8,
  parameter int DWIDTH         = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 startIn,
  input  logic [CRC_WIDTH-1:0] GenPoly,
  input  logic [CRC_WIDTH-1:0] initVal,
  input  logic [CRC_WIDTH-1:0] xorOut,
  input  logic                 reflectIn,
  input  logic                 reflectOut,
  input  logic                 dataValid,
  input  logic [DWIDTH-1:0]    dataIn,
  input  logic                 dataLast,
  output logic                 dataReady,
  output logic                 crcValid,
  output logic [CRC_WIDTH-1:0] crcOut,
  input  logic                 crcAck,
  output logic                 busy
);

  localparam int N     = DWIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (clog2(N) < 1) ? 1 : clog2(N);

  if ((DWIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
    $error("BITS_PER_CYCLE must divide DWIDTH");
  end
  if (CRC_WIDTH < 2 || CRC_WIDTH > MAX_REV_W || DWIDTH > MAX_REV_W) begin : g_bad_width
    $error("CRC_WIDTH must be 2..64 and DWIDTH at most 64");
  end

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CRC_WIDTH-1:0] crc_q, crc_d;
  logic [CRC_WIDTH-1:0] poly_q, poly_d;
  logic [CRC_WIDTH-1:0] xor_q, xor_d;
  logic                 rin_q, rin_d;
  logic                 rout_q, rout_d;
  logic [DWIDTH-1:0]    shreg_q, shreg_d;
  logic                 last_q, last_d;
  logic [CRC_WIDTH-1:0] crc_out_q, crc_out_d;
  logic                 crc_vld_q, crc_vld_d;
  logic [CRC_WIDTH-1:0] step_crc;

  crc_step #(
    .CRC_WIDTH      (CRC_WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .crc      (crc_q),
    .poly     (poly_q),
    .bits     (shreg_q[DWIDTH-1 -: BITS_PER_CYCLE]),
    .crc_next (step_crc)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    poly_d    = poly_q;
    xor_d     = xor_q;
    rin_d     = rin_q;
    rout_d    = rout_q;
    shreg_d   = shreg_q;
    last_d    = last_q;
    crc_out_d = crc_out_q;
    crc_vld_d = crc_vld_q;

    // startIn overrides everything, including a same-cycle crcAck or data beat.
    if (startIn) begin
      poly_d    = GenPoly;
      crc_d     = initVal;
      xor_d     = xorOut;
      rin_d     = reflectIn;
      rout_d    = reflectOut;
      crc_vld_d = 1'b0;
      cnt_d     = '0;
      state_d   = ACCEPT;
    end else begin
      case (state_q)
        ACCEPT: begin
          if (dataValid) begin
            shreg_d = rin_q ? DWIDTH'(bit_reverse(MAX_REV_W'(dataIn), DWIDTH)) : dataIn;
            last_d  = dataLast;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          crc_d   = step_crc;
          shreg_d = shreg_q << BITS_PER_CYCLE;
          if (cnt_q == CNT_W'(N - 1)) begin
            cnt_d = '0;
            if (last_q) begin
              crc_out_d = (rout_q ? CRC_WIDTH'(bit_reverse(MAX_REV_W'(step_crc), CRC_WIDTH))
                                  : step_crc) ^ xor_q;
              crc_vld_d = 1'b1;
              state_d   = DONE;
            end else begin
              state_d = ACCEPT;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (crcAck) begin
            crc_vld_d = 1'b0;
            state_d   = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      crc_q     <= '0;
      poly_q    <= '0;
      xor_q     <= '0;
      rin_q     <= 1'b0;
      rout_q    <= 1'b0;
      shreg_q   <= '0;
      last_q    <= 1'b0;
      crc_out_q <= '0;
      crc_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      poly_q    <= poly_d;
      xor_q     <= xor_d;
      rin_q     <= rin_d;
      rout_q    <= rout_d;
      shreg_q   <= shreg_d;
      last_q    <= last_d;
      crc_out_q <= crc_out_d;
      crc_vld_q <= crc_vld_d;
    end
  end

  assign dataReady = (state_q == ACCEPT) && !startIn;
  assign crcValid  = crc_vld_q;
  assign crcOut    = crc_out_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: three instances (CRC-8 bit-serial, CRC-16 nibble, CRC-32 byte),
// directed messages with known check values; a monitor pops expected results as crcValid rises.
module tb_crc_stream_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start [3];
  logic [31:0] poly  [3];
  logic [31:0] init_v[3];
  logic [31:0] xo    [3];
  logic        rin   [3];
  logic        rout  [3];
  logic        dvld  [3];
  logic [7:0]  din   [3];
  logic        dlast [3];
  logic        ack   [3];
  logic        drdy  [3];
  logic        cvld  [3];
  logic        bsy   [3];
  logic [7:0]  cout8;
  logic [15:0] cout16;
  logic [31:0] cout32;
  logic [31:0] cout_w[3];

  always_comb begin
    cout_w[0] = {24'd0, cout8};
    cout_w[1] = {16'd0, cout16};
    cout_w[2] = cout32;
  end

  crc_stream_engine #(.CRC_WIDTH(8), .DWIDTH(8), .BITS_PER_CYCLE(1)) u_crc8 (
    .clk(clk), .rst(rst), .startIn(start[0]), .GenPoly(poly[0][7:0]), .initVal(init_v[0][7:0]),
    .xorOut(xo[0][7:0]), .reflectIn(rin[0]), .reflectOut(rout[0]), .dataValid(dvld[0]),
    .dataIn(din[0]), .dataLast(dlast[0]), .dataReady(drdy[0]), .crcValid(cvld[0]),
    .crcOut(cout8), .crcAck(ack[0]), .busy(bsy[0]));

  crc_stream_engine #(.CRC_WIDTH(16), .DWIDTH(8), .BITS_PER_CYCLE(4)) u_crc16 (
    .clk(clk), .rst(rst), .startIn(start[1]), .GenPoly(poly[1][15:0]), .initVal(init_v[1][15:0]),
    .xorOut(xo[1][15:0]), .reflectIn(rin[1]), .reflectOut(rout[1]), .dataValid(dvld[1]),
    .dataIn(din[1]), .dataLast(dlast[1]), .dataReady(drdy[1]), .crcValid(cvld[1]),
    .crcOut(cout16), .crcAck(ack[1]), .busy(bsy[1]));

  crc_stream_engine #(.CRC_WIDTH(32), .DWIDTH(8), .BITS_PER_CYCLE(8)) u_crc32 (
    .clk(clk), .rst(rst), .startIn(start[2]), .GenPoly(poly[2]), .initVal(init_v[2]),
    .xorOut(xo[2]), .reflectIn(rin[2]), .reflectOut(rout[2]), .dataValid(dvld[2]),
    .dataIn(din[2]), .dataLast(dlast[2]), .dataReady(drdy[2]), .crcValid(cvld[2]),
    .crcOut(cout32), .crcAck(ack[2]), .busy(bsy[2]));

  typedef struct {
    int          idx;
    logic [31:0] val;
    int          lat;   // cycles from startIn to crcValid, -1 = not checked
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  msg[$];
  int          start_cyc[3];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        cvld_prev[3];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: every rising crcValid must match the oldest expected result.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (cvld[i] === 1'b1 && cvld_prev[i] !== 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: inst %0d raised crcValid with 0x%0h, none expected",
                   i, cout_w[i]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.idx != i || cout_w[i] !== e.val) begin
            n_fail++;
            $display("FAIL crc_value: inst %0d got 0x%0h, expected inst %0d 0x%0h",
                     i, cout_w[i], e.idx, e.val);
          end
          if (e.lat >= 0) begin
            n_checks++;
            if (cyc - start_cyc[i] != e.lat) begin
              n_fail++;
              $display("FAIL crc_latency: inst %0d got %0d cycles, expected %0d",
                       i, cyc - start_cyc[i], e.lat);
            end
          end
        end
      end
      cvld_prev[i] = cvld[i];
    end
  end

  task automatic expect_crc(input int i, input logic [31:0] val, input int lat);
    exp_t e;
    e.idx = i; e.val = val; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic start_msg(input int i, input logic [31:0] p, input logic [31:0] iv,
                           input logic [31:0] x, input logic ri, input logic ro);
    @(posedge clk); #1;
    poly[i] = p; init_v[i] = iv; xo[i] = x; rin[i] = ri; rout[i] = ro;
    start[i] = 1'b1;
    start_cyc[i] = cyc;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  task automatic feed(input int i, input bit gaps, input int nb, input bit mark_last);
    for (int k = 0; k < nb; k++) begin
      bit hs;
      int t;
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
      end
      din[i] = msg[k];
      dlast[i] = mark_last && (k == nb - 1);
      dvld[i] = 1'b1;
      hs = 1'b0;
      t = 0;
      while (!hs && t < 300) begin
        @(negedge clk);
        hs = drdy[i];
        @(posedge clk); #1;
        t++;
      end
      dvld[i] = 1'b0;
      dlast[i] = 1'b0;
      if (!hs) begin
        n_checks++;
        n_fail++;
        $display("FAIL handshake_timeout: inst %0d byte %0d not accepted", i, k);
      end
    end
  endtask

  task automatic wait_result(input int i, input bit do_ack);
    int t;
    t = 0;
    @(negedge clk);
    while (cvld[i] !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (cvld[i] !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_timeout: inst %0d crcValid never rose", i);
    end
    if (do_ack) begin
      @(posedge clk); #1;
      ack[i] = 1'b1;
      @(posedge clk); #1;
      ack[i] = 1'b0;
      @(negedge clk);
      check("ack_clears_valid", 32'(cvld[i]), 32'd0);
      check("ack_clears_busy", 32'(bsy[i]), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input int i);
    check("rst_dataReady", 32'(drdy[i]), 32'd0);
    check("rst_crcValid", 32'(cvld[i]), 32'd0);
    check("rst_busy", 32'(bsy[i]), 32'd0);
    check("rst_crcOut", cout_w[i], 32'd0);
  endtask

  task automatic load_check_string();
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int held;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i] = 0; poly[i] = 0; init_v[i] = 0; xo[i] = 0; rin[i] = 0; rout[i] = 0;
      dvld[i] = 0; din[i] = 0; dlast[i] = 0; ack[i] = 0; cvld_prev[i] = 0; start_cyc[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_reset_outputs(i);
    @(posedge clk); #1;
    rst = 1'b0;

    // CRC-8, bit-serial: 9 cycles per byte
    load_check_string();
    expect_crc(0, 32'hF4, 1 + 9 * 9);
    start_msg(0, 32'h07, 32'h0, 32'h0, 1'b0, 1'b0);
    feed(0, 1'b0, 9, 1'b1);
    wait_result(0, 1'b1);

    // CRC-16/CCITT-FALSE, 4 bits per cycle: 3 cycles per byte
    expect_crc(1, 32'h29B1, 1 + 9 * 3);
    start_msg(1, 32'h1021, 32'hFFFF, 32'h0, 1'b0, 1'b0);
    feed(1, 1'b0, 9, 1'b1);
    wait_result(1, 1'b1);

    // CRC-32, whole byte per cycle, both reflections
    expect_crc(2, 32'hCBF43926, 1 + 9 * 2);
    start_msg(2, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
    feed(2, 1'b0, 9, 1'b1);
    wait_result(2, 1'b1);

    // Same CRC-32 with random gaps on dataValid
    expect_crc(2, 32'hCBF43926, -1);
    start_msg(2, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
    feed(2, 1'b1, 9, 1'b1);
    wait_result(2, 1'b1);

    // CRC-32 of "a"
    msg = '{8'h61};
    expect_crc(2, 32'hE8B7BE43, 3);
    start_msg(2, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
    feed(2, 1'b0, 1, 1'b1);
    wait_result(2, 1'b1);

    // Single-byte CRC-8 corner cases: table entry, xorOut, reflectOut, reflectIn
    msg = '{8'h80};
    expect_crc(0, 32'h89, 10);
    start_msg(0, 32'h07, 32'h0, 32'h0, 1'b0, 1'b0);
    feed(0, 1'b0, 1, 1'b1);
    wait_result(0, 1'b1);

    msg = '{8'h01};
    expect_crc(0, 32'hF8, 10);
    start_msg(0, 32'h07, 32'h0, 32'hFF, 1'b0, 1'b0);
    feed(0, 1'b0, 1, 1'b1);
    wait_result(0, 1'b1);

    expect_crc(0, 32'hE0, 10);
    start_msg(0, 32'h07, 32'h0, 32'h0, 1'b0, 1'b1);
    feed(0, 1'b0, 1, 1'b1);
    wait_result(0, 1'b1);

    msg = '{8'h80};
    expect_crc(0, 32'h07, 10);
    start_msg(0, 32'h07, 32'h0, 32'h0, 1'b1, 1'b0);
    feed(0, 1'b0, 1, 1'b1);
    wait_result(0, 1'b1);

    // Abort: restart mid-SHIFT after 4 bytes; only the second message may produce a result
    load_check_string();
    start_msg(0, 32'h07, 32'h55, 32'h0, 1'b0, 1'b0);
    feed(0, 1'b0, 4, 1'b0);
    check("abort_busy_before_restart", 32'(bsy[0]), 32'd1);
    expect_crc(0, 32'hF4, 1 + 9 * 9);
    start_msg(0, 32'h07, 32'h0, 32'h0, 1'b0, 1'b0);
    feed(0, 1'b0, 9, 1'b1);
    wait_result(0, 1'b1);

    // Reset mid-SHIFT, previous crcOut (0xF4) must clear
    start_msg(0, 32'h07, 32'h0, 32'h0, 1'b0, 1'b0);
    feed(0, 1'b0, 2, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs(0);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_crc(0, 32'hF4, 1 + 9 * 9);
    start_msg(0, 32'h07, 32'h0, 32'h0, 1'b0, 1'b0);
    feed(0, 1'b0, 9, 1'b1);
    wait_result(0, 1'b1);

    // Result held without crcAck, then crcAck and startIn together
    expect_crc(1, 32'h29B1, 1 + 9 * 3);
    start_msg(1, 32'h1021, 32'hFFFF, 32'h0, 1'b0, 1'b0);
    feed(1, 1'b0, 9, 1'b1);
    wait_result(1, 1'b0);
    held = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cvld[1] === 1'b1 && cout_w[1] === 32'h29B1) held++;
    end
    check("valid_held_20_cycles", 32'(held), 32'd20);
    @(posedge clk); #1;
    ack[1] = 1'b1;
    start[1] = 1'b1;
    start_cyc[1] = cyc;
    @(posedge clk); #1;
    ack[1] = 1'b0;
    start[1] = 1'b0;
    @(negedge clk);
    check("ack_start_valid_low", 32'(cvld[1]), 32'd0);
    check("ack_start_busy", 32'(bsy[1]), 32'd1);
    check("ack_start_ready", 32'(drdy[1]), 32'd1);
    expect_crc(1, 32'h29B1, 2 + 9 * 3);
    @(posedge clk); #1;
    feed(1, 1'b0, 9, 1'b1);
    wait_result(1, 1'b1);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
